// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory among N_PORTS requesters; in-order tagged responses.
// Latency: accept to response strobe MEM_LAT+1 edges; no response backpressure, request stalls only via req_ready_o.
module mem_port_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int RR_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            flush_i,
    input  logic [N_PORTS-1:0]            req_valid_i,
    output logic [N_PORTS-1:0]            req_ready_o,
    input  logic [N_PORTS-1:0]            req_we_i,
    input  logic [N_PORTS*ADDR_W-1:0]     req_addr_i,
    input  logic [N_PORTS*DATA_W-1:0]     req_wdata_i,
    input  logic [N_PORTS*DATA_W/8-1:0]   req_be_i,
    output logic [N_PORTS-1:0]            resp_valid_o,
    output logic [DATA_W-1:0]             resp_rdata_o,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    output logic [DATA_W/8-1:0]           mem_be_o,
    input  logic [DATA_W-1:0]             mem_rdata_i
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PID_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int DEPTH = MEM_LAT + 1;

    logic                          gnt_vld;
    logic [PID_W-1:0]              gnt_id;
    logic                          accept;
    int                            cand;
    logic [PID_W-1:0]              cand_id;

    logic [PID_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [DEPTH-1:0]              tag_vld_q, tag_vld_d;
    logic [DEPTH-1:0]              tag_we_q, tag_we_d;
    logic [DEPTH-1:0][PID_W-1:0]   tag_pid_q, tag_pid_d;

    logic                          mem_en_q, mem_en_d;
    logic                          mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]             mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]               mem_be_q, mem_be_d;
    logic [N_PORTS-1:0]            resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]             resp_rdata_q, resp_rdata_d;

    // Scan from the highest search offset down so the first candidate in priority order wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = 0;
        cand_id = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            cand = k;
            if (RR_MODE != 0) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= N_PORTS) cand = cand - N_PORTS;
            end
            cand_id = PID_W'(cand);
            if (req_valid_i[cand_id]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand_id;
            end
        end
    end

    assign accept = gnt_vld & ~flush_i[gnt_id] & ~rst;

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[gnt_id] = 1'b1;
    end

    always_comb begin
        mem_en_d    = accept;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            mem_we_d    = req_we_i[gnt_id];
            mem_addr_d  = req_addr_i[int'(gnt_id)*ADDR_W +: ADDR_W];
            mem_wdata_d = req_wdata_i[int'(gnt_id)*DATA_W +: DATA_W];
            mem_be_d    = req_be_i[int'(gnt_id)*BE_W +: BE_W];
            if (N_PORTS > 1) begin
                rr_ptr_d = (int'(gnt_id) == N_PORTS - 1) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    // Flush masks tags as they advance, including the one leaving the tail this edge.
    always_comb begin
        tag_vld_d    = '0;
        tag_we_d     = '0;
        tag_pid_d    = '0;
        tag_vld_d[0] = accept;
        tag_we_d[0]  = req_we_i[gnt_id];
        tag_pid_d[0] = gnt_id;
        for (int k = 1; k < DEPTH; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1] & ~flush_i[tag_pid_q[k-1]];
            tag_we_d[k]  = tag_we_q[k-1];
            tag_pid_d[k] = tag_pid_q[k-1];
        end
        resp_valid_d = '0;
        resp_rdata_d = '0;
        if (tag_vld_q[DEPTH-1] && !flush_i[tag_pid_q[DEPTH-1]]) begin
            resp_valid_d[tag_pid_q[DEPTH-1]] = 1'b1;
            if (!tag_we_q[DEPTH-1]) resp_rdata_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            tag_vld_q    <= '0;
            tag_we_q     <= '0;
            tag_pid_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q    <= tag_vld_d;
            tag_we_q     <= tag_we_d;
            tag_pid_q    <= tag_pid_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_be_o     = mem_be_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter instances (2-port fixed priority MEM_LAT=1, 3-port round-robin MEM_LAT=2) against a
// transaction-level model: expected grants, command fields and a queue of due responses.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  vld [2];
    logic [2:0]  wer [2];
    logic [2:0]  fl  [2];
    logic [7:0]  ad  [2][3];
    logic [31:0] wd  [2][3];
    logic [3:0]  bev [2][3];

    wire  [1:0]  a_rdy, a_rv;
    wire  [2:0]  rdy [2];
    wire  [2:0]  rv  [2];
    wire         en  [2];
    wire         mwe [2];
    wire  [7:0]  maddr [2];
    wire  [31:0] mwd [2];
    wire  [31:0] rdat [2];
    wire  [3:0]  mbe [2];
    wire  [31:0] mrd [2];

    assign rdy[0] = {1'b0, a_rdy};
    assign rv[0]  = {1'b0, a_rv};

    mem_port_arbiter #(.N_PORTS(2), .ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .RR_MODE(0)) u_a (
        .clk(clk), .rst(rst), .flush_i(fl[0][1:0]), .req_valid_i(vld[0][1:0]), .req_ready_o(a_rdy),
        .req_we_i(wer[0][1:0]), .req_addr_i({ad[0][1], ad[0][0]}), .req_wdata_i({wd[0][1], wd[0][0]}),
        .req_be_i({bev[0][1], bev[0][0]}), .resp_valid_o(a_rv), .resp_rdata_o(rdat[0]),
        .mem_en_o(en[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwd[0]),
        .mem_be_o(mbe[0]), .mem_rdata_i(mrd[0]));

    mem_port_arbiter #(.N_PORTS(3), .ADDR_W(8), .DATA_W(32), .MEM_LAT(2), .RR_MODE(1)) u_b (
        .clk(clk), .rst(rst), .flush_i(fl[1]), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
        .req_we_i(wer[1]), .req_addr_i({ad[1][2], ad[1][1], ad[1][0]}),
        .req_wdata_i({wd[1][2], wd[1][1], wd[1][0]}), .req_be_i({bev[1][2], bev[1][1], bev[1][0]}),
        .resp_valid_o(rv[1]), .resp_rdata_o(rdat[1]),
        .mem_en_o(en[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]),
        .mem_be_o(mbe[1]), .mem_rdata_i(mrd[1]));

    function automatic logic [31:0] seed(int d, logic [7:0] a);
        return {a, 8'(d + 1), ~a, a ^ 8'h3C};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] w, logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    function automatic int np(int d);  return (d == 0) ? 2 : 3; endfunction
    function automatic int lat(int d); return (d == 0) ? 1 : 2; endfunction

    // Environment memories: sample the registered command, return read data MEM_LAT cycles later.
    logic [31:0] emem [2][256];
    bit          ewr  [2][256];
    logic [31:0] pipe0 [2];
    logic [31:0] pipe1;
    logic        env_clr;

    function automatic logic [31:0] rdw(int d, logic [7:0] a);
        return ewr[d][a] ? emem[d][a] : seed(d, a);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (env_clr) begin
                for (int a = 0; a < 256; a++) ewr[d][a] <= 1'b0;
            end else if (en[d]) begin
                if (mwe[d]) begin
                    emem[d][maddr[d]] <= merge(rdw(d, maddr[d]), mwd[d], mbe[d]);
                    ewr[d][maddr[d]]  <= 1'b1;
                end else begin
                    pipe0[d] <= rdw(d, maddr[d]);
                end
            end
        end
        pipe1 <= pipe0[1];
    end
    assign mrd[0] = pipe0[0];
    assign mrd[1] = pipe1;

    // Reference model state
    typedef struct { int d; int due; int port; logic [31:0] data; } exp_t;
    exp_t        q[$];
    logic [31:0] mm [2][256];
    int          ptr [2];
    logic        xen [2];
    logic        xwe [2];
    logic [7:0]  xaddr [2];
    logic [31:0] xwd [2];
    logic [3:0]  xbe [2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", d, tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0; xen[d] = 0; xwe[d] = 0; xaddr[d] = 0; xwd[d] = 0; xbe[d] = 0;
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            vld[d] = '0; wer[d] = '0; fl[d] = '0;
            for (int p = 0; p < 3; p++) begin ad[d][p] = '0; wd[d][p] = '0; bev[d][p] = '0; end
        end
    endtask

    task automatic req(input int d, input int p, input logic w, input logic [7:0] a,
                       input logic [31:0] data, input logic [3:0] b);
        vld[d][p] = 1'b1; wer[d][p] = w; ad[d][p] = a; wd[d][p] = data; bev[d][p] = b;
    endtask

    task automatic check_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            logic [2:0]  ev;
            logic [31:0] er;
            ev = '0; er = '0;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].d == d && q[i].due == cyc) begin
                    ev[q[i].port] = 1'b1; er = q[i].data; q.delete(i); break;
                end
            end
            chk(d, {tag, ".resp_valid"}, rv[d], ev);
            chk(d, {tag, ".resp_rdata"}, rdat[d], er);
            chk(d, {tag, ".mem_en"}, en[d], xen[d]);
            chk(d, {tag, ".mem_we"}, mwe[d], xwe[d]);
            chk(d, {tag, ".mem_addr"}, maddr[d], xaddr[d]);
            chk(d, {tag, ".mem_wdata"}, mwd[d], xwd[d]);
            chk(d, {tag, ".mem_be"}, mbe[d], xbe[d]);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int g;
            logic acc;
            logic [2:0] er;
            g = -1;
            if (!rst) begin
                for (int k = 0; k < np(d); k++) begin
                    int p;
                    p = (d == 1) ? (ptr[d] + k) % np(d) : k;
                    if (g < 0 && vld[d][p]) g = p;
                end
            end
            acc = (g >= 0) && !fl[d][g];
            er = '0;
            if (acc) er[g] = 1'b1;
            chk(d, "req_ready", rdy[d], er);
            if (!rst) begin
                for (int i = q.size() - 1; i >= 0; i--)
                    if (q[i].d == d && fl[d][q[i].port]) q.delete(i);
            end
            xen[d] = acc;
            if (acc) begin
                logic [7:0] a;
                logic [31:0] data;
                a = ad[d][g];
                xwe[d] = wer[d][g]; xaddr[d] = a; xwd[d] = wd[d][g]; xbe[d] = bev[d][g];
                if (wer[d][g]) begin
                    mm[d][a] = merge(mm[d][a], wd[d][g], bev[d][g]);
                    data = '0;
                end else begin
                    data = mm[d][a];
                end
                q.push_back('{d, cyc + 1 + lat(d) + 1, g, data});
                if (d == 1) ptr[d] = (g + 1) % np(d);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs("step");
    endtask

    initial begin
        rst = 1'b1;
        env_clr = 1'b1;
        idle();
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a++) mm[d][a] = seed(d, a);
        #1;
        check_outputs("reset");
        cycle();
        env_clr = 1'b0;
        cycle();
        rst = 1'b0;

        // Write then read back through the other port; write acknowledge with partial byte enables
        req(0, 0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF); cycle(); idle();
        req(0, 1, 1'b0, 8'h10, 32'h0, 4'h0); cycle(); idle();
        repeat (4) cycle();
        req(0, 0, 1'b1, 8'h04, 32'hA5A5A5A5, 4'b0011); cycle(); idle();
        req(0, 1, 1'b0, 8'h04, 32'h0, 4'h0); cycle(); idle();
        repeat (4) cycle();

        // Fixed priority contention: port 0 holds the memory for four cycles
        req(0, 0, 1'b0, 8'h01, 32'h0, 4'h0);
        req(0, 1, 1'b0, 8'h02, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin ad[0][0] = 8'(i + 1); cycle(); end
        vld[0][0] = 1'b0; cycle(); idle();
        repeat (4) cycle();

        // Round robin with all three ports continuously valid
        for (int p = 0; p < 3; p++) req(1, p, 1'b0, 8'(p + 5), 32'h0, 4'h0);
        repeat (6) cycle();
        idle();
        repeat (5) cycle();

        // Flush of port 1 after three back-to-back reads, port 0 read in the same cycle
        for (int i = 0; i < 3; i++) begin req(1, 1, 1'b0, 8'(i + 1), 32'h0, 4'h0); cycle(); end
        idle();
        fl[1][1] = 1'b1;
        req(1, 0, 1'b0, 8'h09, 32'h0, 4'h0);
        cycle(); idle();
        repeat (5) cycle();

        // Asynchronous reset with reads in flight
        req(0, 1, 1'b0, 8'h10, 32'h0, 4'h0); req(1, 2, 1'b0, 8'h03, 32'h0, 4'h0); cycle();
        req(0, 0, 1'b0, 8'h04, 32'h0, 4'h0); cycle(); idle();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        repeat (4) cycle();
        rst = 1'b0;
        req(0, 1, 1'b0, 8'h10, 32'h0, 4'h0); req(1, 1, 1'b0, 8'h07, 32'h0, 4'h0); cycle(); idle();
        repeat (5) cycle();

        // Randomized traffic with occasional flushes
        repeat (500) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < np(d); p++) begin
                    vld[d][p] = ($urandom_range(0, 3) != 0);
                    wer[d][p] = ($urandom_range(0, 2) == 0);
                    ad[d][p]  = 8'($urandom_range(0, 15));
                    wd[d][p]  = $urandom;
                    bev[d][p] = 4'($urandom_range(0, 15));
                    fl[d][p]  = ($urandom_range(0, 15) == 0);
                end
            end
            cycle();
        end
        idle();
        repeat (6) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
